// File: rtl/rs_age_sched_pkg.sv
// Shared widths, reservation-station entry payload and the ROB-relative age helper.
package rs_age_sched_pkg;

    localparam int unsigned DEF_RS_ENTRIES = 16;
    localparam int unsigned DEF_ALLOC_W    = 2;
    localparam int unsigned DEF_ISSUE_W    = 2;
    localparam int unsigned DEF_CDB_W      = 2;
    localparam int unsigned PHYS_W         = 6;
    localparam int unsigned ROB_W          = 6;
    localparam int unsigned XLEN           = 64;
    localparam int unsigned OP_W           = 8;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [PHYS_W-1:0] dst_tag;
        logic [PHYS_W-1:0] src1_tag;
        logic [PHYS_W-1:0] src2_tag;
        logic [XLEN-1:0]   src1_val;
        logic [XLEN-1:0]   src2_val;
        logic              src1_rdy;
        logic              src2_rdy;
        logic [ROB_W-1:0]  rob_tag;
    } rs_entry_t;

    // True when tag is strictly younger than ref_tag, both measured as distance from head.
    function automatic logic rob_younger(input logic [ROB_W-1:0] tag,
                                         input logic [ROB_W-1:0] ref_tag,
                                         input logic [ROB_W-1:0] head);
        logic [ROB_W-1:0] d_tag;
        logic [ROB_W-1:0] d_ref;
        d_tag = ROB_W'(tag - head);
        d_ref = ROB_W'(ref_tag - head);
        return d_tag > d_ref;
    endfunction

endpackage

// File: rtl/rs_age_sched_if.sv
// Dispatch / CDB / issue / flush bundle between the backend and the reservation station.
interface rs_age_sched_if
    import rs_age_sched_pkg::*;
#(
    parameter int unsigned RS_ENTRIES = DEF_RS_ENTRIES,
    parameter int unsigned ALLOC_W    = DEF_ALLOC_W,
    parameter int unsigned ISSUE_W    = DEF_ISSUE_W,
    parameter int unsigned CDB_W      = DEF_CDB_W
);
    localparam int unsigned CNT_W = $clog2(RS_ENTRIES) + 1;

    logic [ALLOC_W-1:0]             alloc_en;
    logic                           alloc_ready;
    logic [ALLOC_W-1:0][PHYS_W-1:0] alloc_dst_tag;
    logic [ALLOC_W-1:0][PHYS_W-1:0] alloc_src1_tag;
    logic [ALLOC_W-1:0][PHYS_W-1:0] alloc_src2_tag;
    logic [ALLOC_W-1:0][XLEN-1:0]   alloc_src1_val;
    logic [ALLOC_W-1:0][XLEN-1:0]   alloc_src2_val;
    logic [ALLOC_W-1:0]             alloc_src1_ready;
    logic [ALLOC_W-1:0]             alloc_src2_ready;
    logic [ALLOC_W-1:0][OP_W-1:0]   alloc_op;
    logic [ALLOC_W-1:0][ROB_W-1:0]  alloc_rob_tag;
    logic [CDB_W-1:0]               cdb_valid;
    logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag;
    logic [CDB_W-1:0][XLEN-1:0]     cdb_value;
    logic [ISSUE_W-1:0]             issue_ready;
    logic [ISSUE_W-1:0]             issue_valid;
    logic [ISSUE_W-1:0][OP_W-1:0]   issue_op;
    logic [ISSUE_W-1:0][PHYS_W-1:0] issue_dst_tag;
    logic [ISSUE_W-1:0][XLEN-1:0]   issue_src1_val;
    logic [ISSUE_W-1:0][XLEN-1:0]   issue_src2_val;
    logic [ISSUE_W-1:0][ROB_W-1:0]  issue_rob_tag;
    logic [ROB_W-1:0]               rob_head;
    logic                           flush_all;
    logic                           flush_valid;
    logic [ROB_W-1:0]               flush_rob_tag;
    logic [CNT_W-1:0]               free_count;

    modport master (
        output alloc_en, alloc_dst_tag, alloc_src1_tag, alloc_src2_tag, alloc_src1_val,
               alloc_src2_val, alloc_src1_ready, alloc_src2_ready, alloc_op, alloc_rob_tag,
               cdb_valid, cdb_tag, cdb_value, issue_ready, rob_head, flush_all,
               flush_valid, flush_rob_tag,
        input  alloc_ready, issue_valid, issue_op, issue_dst_tag, issue_src1_val,
               issue_src2_val, issue_rob_tag, free_count
    );

    modport slave (
        input  alloc_en, alloc_dst_tag, alloc_src1_tag, alloc_src2_tag, alloc_src1_val,
               alloc_src2_val, alloc_src1_ready, alloc_src2_ready, alloc_op, alloc_rob_tag,
               cdb_valid, cdb_tag, cdb_value, issue_ready, rob_head, flush_all,
               flush_valid, flush_rob_tag,
        output alloc_ready, issue_valid, issue_op, issue_dst_tag, issue_src1_val,
               issue_src2_val, issue_rob_tag, free_count
    );

endinterface

// File: rtl/rs_age_matrix.sv
// Allocation-order matrix: yields one-hot grants for the ISSUE_W oldest requesting entries.
module rs_age_matrix #(
    parameter int unsigned RS_ENTRIES = 16,
    parameter int unsigned ALLOC_W    = 2,
    parameter int unsigned ISSUE_W    = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ALLOC_W-1:0][RS_ENTRIES-1:0] alloc_oh,
    input  logic [RS_ENTRIES-1:0]              clr,
    input  logic [RS_ENTRIES-1:0]              req,
    output logic [ISSUE_W-1:0][RS_ENTRIES-1:0] grant_c
);
    localparam int unsigned CNT_W = $clog2(RS_ENTRIES) + 1;

    // older_q[i][j] set means entry j was allocated before entry i.
    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older_q, older_d;

    always_comb begin
        older_d = older_q;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (clr[i]) begin
                older_d[i] = '0;
                for (int j = 0; j < RS_ENTRIES; j++) older_d[j][i] = 1'b0;
            end
        end
        // Ports in order, so a lower port ends up older than a higher one in the same cycle.
        for (int p = 0; p < ALLOC_W; p++) begin
            for (int s = 0; s < RS_ENTRIES; s++) begin
                if (alloc_oh[p][s]) begin
                    older_d[s] = '1;
                    for (int j = 0; j < RS_ENTRIES; j++) older_d[j][s] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) older_q <= '0;
        else        older_q <= older_d;
    end

    // Rank = number of older requesters; rank k goes to issue port k.
    always_comb begin
        logic [CNT_W-1:0] rank;
        grant_c = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            rank = '0;
            for (int j = 0; j < RS_ENTRIES; j++) rank = rank + CNT_W'(older_q[i][j] & req[j]);
            for (int k = 0; k < ISSUE_W; k++) begin
                if (req[i] && rank == CNT_W'(k)) grant_c[k][i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_age_sched.sv
// Age-ordered reservation station: N-wide allocate, same-cycle CDB capture, oldest-first issue, ROB-keyed flush.
module rs_age_sched
    import rs_age_sched_pkg::*;
#(
    parameter int unsigned RS_ENTRIES = DEF_RS_ENTRIES,
    parameter int unsigned ALLOC_W    = DEF_ALLOC_W,
    parameter int unsigned ISSUE_W    = DEF_ISSUE_W,
    parameter int unsigned CDB_W      = DEF_CDB_W
) (
    input  logic          clk,
    input  logic          reset,
    rs_age_sched_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(RS_ENTRIES) + 1;

    rs_entry_t [RS_ENTRIES-1:0]         ent_q, ent_d;
    logic [CNT_W-1:0]                   free_count_q, free_count_d;
    logic                               alloc_ready_q, alloc_ready_d;
    logic [ALLOC_W-1:0][RS_ENTRIES-1:0] alloc_oh;
    logic [RS_ENTRIES-1:0]              req, clr;
    logic [ISSUE_W-1:0][RS_ENTRIES-1:0] grant;
    logic [ISSUE_W-1:0]                 issue_fire;
    logic                               flush_any;

    // {hit, value} of the lowest CDB port broadcasting tag.
    function automatic logic [XLEN:0] cdb_match(input logic [PHYS_W-1:0] tag,
                                                input logic [CDB_W-1:0] vld,
                                                input logic [CDB_W-1:0][PHYS_W-1:0] tags,
                                                input logic [CDB_W-1:0][XLEN-1:0] vals);
        logic [XLEN:0] res;
        res = '0;
        for (int c = int'(CDB_W) - 1; c >= 0; c--) begin
            if (vld[c] && tags[c] == tag) res = {1'b1, vals[c]};
        end
        return res;
    endfunction

    assign flush_any = bus.flush_all | bus.flush_valid;

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) req[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
    end

    rs_age_matrix #(
        .RS_ENTRIES (RS_ENTRIES),
        .ALLOC_W    (ALLOC_W),
        .ISSUE_W    (ISSUE_W)
    ) u_age (
        .clk      (clk),
        .reset    (reset),
        .alloc_oh (alloc_oh),
        .clr      (clr),
        .req      (req),
        .grant_c  (grant)
    );

    // Issue presentation is a pure function of registered entries plus the flush kill.
    always_comb begin
        bus.issue_valid    = '0;
        bus.issue_op       = '0;
        bus.issue_dst_tag  = '0;
        bus.issue_src1_val = '0;
        bus.issue_src2_val = '0;
        bus.issue_rob_tag  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            bus.issue_valid[k] = (|grant[k]) && !flush_any;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (grant[k][i] && !flush_any) begin
                    bus.issue_op[k]       = ent_q[i].op;
                    bus.issue_dst_tag[k]  = ent_q[i].dst_tag;
                    bus.issue_src1_val[k] = ent_q[i].src1_val;
                    bus.issue_src2_val[k] = ent_q[i].src2_val;
                    bus.issue_rob_tag[k]  = ent_q[i].rob_tag;
                end
            end
        end
    end

    assign issue_fire = bus.issue_valid & bus.issue_ready;

    // Lowest free slots, port 0 first; requests are dropped when not ready or flushing.
    always_comb begin
        logic [RS_ENTRIES-1:0] avail;
        logic                  found;
        alloc_oh = '0;
        for (int i = 0; i < RS_ENTRIES; i++) avail[i] = !ent_q[i].valid;
        for (int p = 0; p < ALLOC_W; p++) begin
            found = 1'b0;
            if (bus.alloc_en[p] && alloc_ready_q && !flush_any) begin
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (!found && avail[i]) begin
                        alloc_oh[p][i] = 1'b1;
                        avail[i]       = 1'b0;
                        found          = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        logic [XLEN:0] hit;
        rs_entry_t     ne;
        ent_d = ent_q;
        clr   = '0;
        hit   = '0;
        ne    = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (ent_q[i].valid && !ent_q[i].src1_rdy) begin
                hit = cdb_match(ent_q[i].src1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                if (hit[XLEN]) begin
                    ent_d[i].src1_rdy = 1'b1;
                    ent_d[i].src1_val = hit[XLEN-1:0];
                end
            end
            if (ent_q[i].valid && !ent_q[i].src2_rdy) begin
                hit = cdb_match(ent_q[i].src2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                if (hit[XLEN]) begin
                    ent_d[i].src2_rdy = 1'b1;
                    ent_d[i].src2_val = hit[XLEN-1:0];
                end
            end
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (grant[k][i] && issue_fire[k]) begin
                    ent_d[i].valid = 1'b0;
                    clr[i]         = 1'b1;
                end
            end
        end
        for (int p = 0; p < ALLOC_W; p++) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (alloc_oh[p][i]) begin
                    ne          = '0;
                    ne.valid    = 1'b1;
                    ne.op       = bus.alloc_op[p];
                    ne.dst_tag  = bus.alloc_dst_tag[p];
                    ne.src1_tag = bus.alloc_src1_tag[p];
                    ne.src2_tag = bus.alloc_src2_tag[p];
                    ne.src1_val = bus.alloc_src1_val[p];
                    ne.src2_val = bus.alloc_src2_val[p];
                    ne.src1_rdy = bus.alloc_src1_ready[p];
                    ne.src2_rdy = bus.alloc_src2_ready[p];
                    ne.rob_tag  = bus.alloc_rob_tag[p];
                    if (!ne.src1_rdy) begin
                        hit = cdb_match(ne.src1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                        if (hit[XLEN]) begin
                            ne.src1_rdy = 1'b1;
                            ne.src1_val = hit[XLEN-1:0];
                        end
                    end
                    if (!ne.src2_rdy) begin
                        hit = cdb_match(ne.src2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                        if (hit[XLEN]) begin
                            ne.src2_rdy = 1'b1;
                            ne.src2_val = hit[XLEN-1:0];
                        end
                    end
                    ent_d[i] = ne;
                end
            end
        end
        // Flush overrides everything above.
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (bus.flush_all ||
                (bus.flush_valid && rob_younger(ent_q[i].rob_tag, bus.flush_rob_tag, bus.rob_head))) begin
                ent_d[i].valid = 1'b0;
                clr[i]         = 1'b1;
            end
        end
    end

    always_comb begin
        logic [CNT_W-1:0] used;
        used = '0;
        for (int i = 0; i < RS_ENTRIES; i++) used = used + CNT_W'(ent_d[i].valid);
        free_count_d  = CNT_W'(RS_ENTRIES) - used;
        alloc_ready_d = free_count_d >= CNT_W'(ALLOC_W);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_q         <= '0;
            free_count_q  <= CNT_W'(RS_ENTRIES);
            alloc_ready_q <= 1'b1;
        end else begin
            ent_q         <= ent_d;
            free_count_q  <= free_count_d;
            alloc_ready_q <= alloc_ready_d;
        end
    end

    assign bus.free_count  = free_count_q;
    assign bus.alloc_ready = alloc_ready_q;

endmodule

// File: tb/tb_rs_age_sched.sv
// Directed bench for rs_age_sched: dependency chain, bypass, ordering, flushes and reset.
module tb_rs_age_sched;
    import rs_age_sched_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    rs_age_sched_if bus ();

    rs_age_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.alloc_en    = '0;
        bus.cdb_valid   = '0;
        bus.flush_all   = 1'b0;
        bus.flush_valid = 1'b0;
        #1;
    endtask

    task automatic set_alloc(input int p, input logic [OP_W-1:0] op, input logic [PHYS_W-1:0] dst,
                             input logic [PHYS_W-1:0] s1t, input logic [XLEN-1:0] s1v, input logic s1r,
                             input logic [PHYS_W-1:0] s2t, input logic [XLEN-1:0] s2v, input logic s2r,
                             input logic [ROB_W-1:0] rob);
        bus.alloc_op[p]         = op;
        bus.alloc_dst_tag[p]    = dst;
        bus.alloc_src1_tag[p]   = s1t;
        bus.alloc_src1_val[p]   = s1v;
        bus.alloc_src1_ready[p] = s1r;
        bus.alloc_src2_tag[p]   = s2t;
        bus.alloc_src2_val[p]   = s2v;
        bus.alloc_src2_ready[p] = s2r;
        bus.alloc_rob_tag[p]    = rob;
    endtask

    task automatic set_ready_alloc(input int p, input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob);
        set_alloc(p, op, PHYS_W'(op), 6'd0, 64'(op), 1'b1, 6'd0, 64'(op) + 64'd1, 1'b1, rob);
    endtask

    initial begin
        reset             = 1'b0;
        bus.alloc_en      = '0;
        bus.alloc_op      = '0;
        bus.alloc_dst_tag = '0;
        bus.alloc_src1_tag = '0;
        bus.alloc_src2_tag = '0;
        bus.alloc_src1_val = '0;
        bus.alloc_src2_val = '0;
        bus.alloc_src1_ready = '0;
        bus.alloc_src2_ready = '0;
        bus.alloc_rob_tag = '0;
        bus.cdb_valid     = '0;
        bus.cdb_tag       = '0;
        bus.cdb_value     = '0;
        bus.issue_ready   = 2'b11;
        bus.rob_head      = '0;
        bus.flush_all     = 1'b0;
        bus.flush_valid   = 1'b0;
        bus.flush_rob_tag = '0;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check("rst issue_valid", 64'(bus.issue_valid), 64'd0);
        check("rst issue_op", 64'(bus.issue_op), 64'd0);
        check("rst issue_src1", 64'(bus.issue_src1_val[0]), 64'd0);
        check("rst alloc_ready", 64'(bus.alloc_ready), 64'd1);
        check("rst free_count", 64'(bus.free_count), 64'd16);

        // 1: ADD p10=p1+p2 ready, SUB p11=p10+p3 waits for CDB p10=8
        set_alloc(0, 8'h01, 6'd10, 6'd1, 64'd5, 1'b1, 6'd2, 64'd3, 1'b1, 6'd0);
        set_alloc(1, 8'h02, 6'd11, 6'd10, 64'd0, 1'b0, 6'd3, 64'd7, 1'b1, 6'd1);
        bus.alloc_en = 2'b11;
        #1;
        check("t1 no same-cycle issue", 64'(bus.issue_valid), 64'd0);
        tick();
        check("t1 add valid", 64'(bus.issue_valid), 64'b01);
        check("t1 add op", 64'(bus.issue_op[0]), 64'h01);
        check("t1 add src1", bus.issue_src1_val[0], 64'd5);
        check("t1 add src2", bus.issue_src2_val[0], 64'd3);
        check("t1 add dst", 64'(bus.issue_dst_tag[0]), 64'd10);
        check("t1 free after alloc", 64'(bus.free_count), 64'd14);
        bus.cdb_valid    = 2'b01;
        bus.cdb_tag[0]   = 6'd10;
        bus.cdb_value[0] = 64'd8;
        tick();
        check("t1 sub valid", 64'(bus.issue_valid), 64'b01);
        check("t1 sub op", 64'(bus.issue_op[0]), 64'h02);
        check("t1 sub src1", bus.issue_src1_val[0], 64'd8);
        check("t1 sub src2", bus.issue_src2_val[0], 64'd7);
        check("t1 sub dst", 64'(bus.issue_dst_tag[0]), 64'd11);
        check("t1 sub rob", 64'(bus.issue_rob_tag[0]), 64'd1);
        check("t1 free after add", 64'(bus.free_count), 64'd15);
        tick();
        check("t1 drained valid", 64'(bus.issue_valid), 64'd0);
        check("t1 drained free", 64'(bus.free_count), 64'd16);

        // 2: allocation bypass from CDB port 1
        set_alloc(0, 8'h03, 6'd21, 6'd20, 64'd0, 1'b0, 6'd4, 64'd1, 1'b1, 6'd2);
        bus.alloc_en     = 2'b01;
        bus.cdb_valid    = 2'b10;
        bus.cdb_tag[1]   = 6'd20;
        bus.cdb_value[1] = 64'd99;
        #1;
        check("t2 no same-cycle issue", 64'(bus.issue_valid), 64'd0);
        tick();
        check("t2 valid", 64'(bus.issue_valid), 64'b01);
        check("t2 op", 64'(bus.issue_op[0]), 64'h03);
        check("t2 src1 bypass", bus.issue_src1_val[0], 64'd99);
        check("t2 src2", bus.issue_src2_val[0], 64'd1);
        check("t2 free", 64'(bus.free_count), 64'd15);
        tick();
        check("t2 drained free", 64'(bus.free_count), 64'd16);

        // 3: fill 15 with port traffic stalled, then drain through port 0 only
        bus.issue_ready = 2'b00;
        for (int c = 0; c < 7; c++) begin
            set_ready_alloc(0, 8'(2 * c + 1), 6'(2 * c + 1));
            set_ready_alloc(1, 8'(2 * c + 2), 6'(2 * c + 2));
            bus.alloc_en = 2'b11;
            tick();
        end
        check("t3 ready at 14", 64'(bus.alloc_ready), 64'd1);
        check("t3 free at 14", 64'(bus.free_count), 64'd2);
        set_ready_alloc(0, 8'd15, 6'd15);
        bus.alloc_en = 2'b01;
        tick();
        check("t3 ready at 15", 64'(bus.alloc_ready), 64'd0);
        check("t3 free at 15", 64'(bus.free_count), 64'd1);
        set_ready_alloc(0, 8'hEE, 6'd20);
        set_ready_alloc(1, 8'hEF, 6'd21);
        bus.alloc_en = 2'b11;
        tick();
        check("t3 alloc ignored", 64'(bus.free_count), 64'd1);
        bus.issue_ready = 2'b01;
        for (int n = 0; n < 15; n++) begin
            check("t3 p0 valid", 64'(bus.issue_valid[0]), 64'd1);
            check("t3 p0 op", 64'(bus.issue_op[0]), 64'(n + 1));
            if (n < 14) begin
                check("t3 p1 valid", 64'(bus.issue_valid[1]), 64'd1);
                check("t3 p1 op", 64'(bus.issue_op[1]), 64'(n + 2));
            end else begin
                check("t3 p1 idle", 64'(bus.issue_valid[1]), 64'd0);
            end
            tick();
            check("t3 free", 64'(bus.free_count), 64'(n + 2));
        end

        // 4: branch flush across ROB wrap, head=60
        bus.issue_ready = 2'b00;
        bus.rob_head    = 6'd60;
        set_ready_alloc(0, 8'h41, 6'd61);
        set_ready_alloc(1, 8'h42, 6'd62);
        bus.alloc_en = 2'b11;
        tick();
        set_ready_alloc(0, 8'h43, 6'd1);
        set_ready_alloc(1, 8'h44, 6'd3);
        bus.alloc_en = 2'b11;
        tick();
        check("t4 free before flush", 64'(bus.free_count), 64'd12);
        check("t4 valid before flush", 64'(bus.issue_valid), 64'b11);
        bus.flush_valid   = 1'b1;
        bus.flush_rob_tag = 6'd62;
        #1;
        check("t4 flush gates issue", 64'(bus.issue_valid), 64'd0);
        tick();
        check("t4 free after flush", 64'(bus.free_count), 64'd14);
        check("t4 survivors valid", 64'(bus.issue_valid), 64'b11);
        check("t4 p0 rob", 64'(bus.issue_rob_tag[0]), 64'd61);
        check("t4 p1 rob", 64'(bus.issue_rob_tag[1]), 64'd62);
        bus.issue_ready = 2'b11;
        tick();
        check("t4 drained free", 64'(bus.free_count), 64'd16);
        check("t4 drained valid", 64'(bus.issue_valid), 64'd0);
        bus.rob_head = 6'd0;

        // 5: flush_all with concurrent ready allocations and a matching CDB
        set_alloc(0, 8'h51, 6'd41, 6'd40, 64'd0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd5);
        set_alloc(1, 8'h52, 6'd42, 6'd40, 64'd0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd6);
        bus.alloc_en = 2'b11;
        tick();
        set_alloc(0, 8'h53, 6'd43, 6'd40, 64'd0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd7);
        bus.alloc_en = 2'b01;
        tick();
        check("t5 free before flush", 64'(bus.free_count), 64'd13);
        set_ready_alloc(0, 8'h54, 6'd8);
        set_ready_alloc(1, 8'h55, 6'd9);
        bus.alloc_en     = 2'b11;
        bus.cdb_valid    = 2'b01;
        bus.cdb_tag[0]   = 6'd40;
        bus.cdb_value[0] = 64'd123;
        bus.flush_all    = 1'b1;
        #1;
        check("t5 flush issue", 64'(bus.issue_valid), 64'd0);
        tick();
        check("t5 free after flush", 64'(bus.free_count), 64'd16);
        check("t5 ready after flush", 64'(bus.alloc_ready), 64'd1);
        check("t5 nothing survives", 64'(bus.issue_valid), 64'd0);

        // 6: reset with 8 live entries
        bus.issue_ready = 2'b00;
        for (int c = 0; c < 4; c++) begin
            set_ready_alloc(0, 8'(8'h60 + 2 * c), 6'(10 + 2 * c));
            set_ready_alloc(1, 8'(8'h61 + 2 * c), 6'(11 + 2 * c));
            bus.alloc_en = 2'b11;
            tick();
        end
        check("t6 free before reset", 64'(bus.free_count), 64'd8);
        check("t6 valid before reset", 64'(bus.issue_valid), 64'b11);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("t6 rst issue_valid", 64'(bus.issue_valid), 64'd0);
        check("t6 rst free", 64'(bus.free_count), 64'd16);
        check("t6 rst alloc_ready", 64'(bus.alloc_ready), 64'd1);
        check("t6 rst issue_op", 64'(bus.issue_op), 64'd0);
        check("t6 rst issue_src1", bus.issue_src1_val[1], 64'd0);
        check("t6 rst issue_rob", 64'(bus.issue_rob_tag), 64'd0);
        bus.issue_ready = 2'b11;
        set_ready_alloc(0, 8'h77, 6'd12);
        bus.alloc_en = 2'b01;
        tick();
        check("t6 resume valid", 64'(bus.issue_valid), 64'b01);
        check("t6 resume op", 64'(bus.issue_op[0]), 64'h77);
        check("t6 resume free", 64'(bus.free_count), 64'd15);
        tick();
        check("t6 resume drained", 64'(bus.free_count), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
